alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state fetch/decode/execute controller for a
// 16-bit register-file ALU datapath, with all outputs registered.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    input  logic        zero,
    output logic        imem_req,
    output logic [2:0]  op_alu,
    output logic [3:0]  ra_addr,
    output logic [3:0]  rb_addr,
    output logic [3:0]  wa_addr,
    output logic        we3,
    output logic        s_inm,
    output logic [15:0] inm,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [9:0]  jaddr,
    output logic        zflag,
    output logic        busy,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        zflag_q, zflag_d;
    logic        imem_req_q, imem_req_d;
    logic [2:0]  op_alu_q, op_alu_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  wa_q, wa_d;
    logic        we3_q, we3_d;
    logic        s_inm_q, s_inm_d;
    logic [15:0] inm_q, inm_d;
    logic        pc_inc_q, pc_inc_d;
    logic        pc_load_q, pc_load_d;
    logic [9:0]  jaddr_q, jaddr_d;
    logic        busy_q, busy_d;
    logic        illegal_q, illegal_d;

    // Next state and next registered outputs; outputs for a state are
    // computed on the edge that enters it, so EXEC sees the old zflag.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        zflag_d    = zflag_q;
        imem_req_d = 1'b0;
        op_alu_d   = 3'd0;
        ra_d       = 4'd0;
        rb_d       = 4'd0;
        wa_d       = 4'd0;
        we3_d      = 1'b0;
        s_inm_d    = 1'b0;
        inm_d      = 16'd0;
        pc_inc_d   = 1'b0;
        pc_load_d  = 1'b0;
        jaddr_d    = 10'd0;
        illegal_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_FETCH;
                    imem_req_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                    ra_d    = instr[7:4];
                    rb_d    = instr[3:0];
                    if (instr[15]) begin
                        op_alu_d = instr[14:12];
                    end
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                casez (ir_q[15:12])
                    4'b1???: begin
                        we3_d    = 1'b1;
                        wa_d     = ir_q[11:8];
                        op_alu_d = ir_q[14:12];
                        ra_d     = ir_q[7:4];
                        rb_d     = ir_q[3:0];
                        pc_inc_d = 1'b1;
                    end
                    4'b0000: begin
                        we3_d    = 1'b1;
                        s_inm_d  = 1'b1;
                        inm_d    = {8'h00, ir_q[7:0]};
                        wa_d     = ir_q[11:8];
                        pc_inc_d = 1'b1;
                    end
                    4'b0001: begin
                        pc_load_d = 1'b1;
                        jaddr_d   = ir_q[9:0];
                    end
                    4'b0010: begin
                        jaddr_d   = ir_q[9:0];
                        pc_load_d = zflag_q;
                        pc_inc_d  = !zflag_q;
                    end
                    4'b0011: begin
                        jaddr_d   = ir_q[9:0];
                        pc_load_d = !zflag_q;
                        pc_inc_d  = zflag_q;
                    end
                    4'b0100: begin
                        pc_inc_d = 1'b1;
                    end
                    default: begin
                        pc_inc_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (ir_q[15]) begin
                    zflag_d = zero;
                end
                if (run) begin
                    state_d    = S_FETCH;
                    imem_req_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, IR, flag and output registers; reset beats every event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= 16'd0;
            zflag_q    <= 1'b0;
            imem_req_q <= 1'b0;
            op_alu_q   <= 3'd0;
            ra_q       <= 4'd0;
            rb_q       <= 4'd0;
            wa_q       <= 4'd0;
            we3_q      <= 1'b0;
            s_inm_q    <= 1'b0;
            inm_q      <= 16'd0;
            pc_inc_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            jaddr_q    <= 10'd0;
            busy_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            zflag_q    <= zflag_d;
            imem_req_q <= imem_req_d;
            op_alu_q   <= op_alu_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            wa_q       <= wa_d;
            we3_q      <= we3_d;
            s_inm_q    <= s_inm_d;
            inm_q      <= inm_d;
            pc_inc_q   <= pc_inc_d;
            pc_load_q  <= pc_load_d;
            jaddr_q    <= jaddr_d;
            busy_q     <= busy_d;
            illegal_q  <= illegal_d;
        end
    end

    assign imem_req = imem_req_q;
    assign op_alu   = op_alu_q;
    assign ra_addr  = ra_q;
    assign rb_addr  = rb_q;
    assign wa_addr  = wa_q;
    assign we3      = we3_q;
    assign s_inm    = s_inm_q;
    assign inm      = inm_q;
    assign pc_inc   = pc_inc_q;
    assign pc_load  = pc_load_q;
    assign jaddr    = jaddr_q;
    assign zflag    = zflag_q;
    assign busy     = busy_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; the driver pushes expected
// EXEC behaviour per instruction, a negedge monitor pops and compares.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        zero = 1'b0;
    logic        imem_req;
    logic [2:0]  op_alu;
    logic [3:0]  ra_addr, rb_addr, wa_addr;
    logic        we3, s_inm;
    logic [15:0] inm;
    logic        pc_inc, pc_load;
    logic [9:0]  jaddr;
    logic        zflag, busy, illegal;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .imem_ack(imem_ack),
        .instr(instr), .zero(zero), .imem_req(imem_req),
        .op_alu(op_alu), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .wa_addr(wa_addr), .we3(we3), .s_inm(s_inm), .inm(inm),
        .pc_inc(pc_inc), .pc_load(pc_load), .jaddr(jaddr),
        .zflag(zflag), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          alu;
        logic [2:0]  op;
        logic [3:0]  ra, rb, wa;
        logic        we3, s_inm;
        logic [15:0] inm;
        logic        pc_inc, pc_load;
        logic [9:0]  jaddr;
        logic        ill;
        logic        zf;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   zf_m = 1'b0;
    bit   jitter = 1'b0;
    bit   rand_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     n, a, e, cyc);
        end
    endtask

    // Instruction semantics from the opcode table, flag given.
    function automatic exp_t model(input logic [15:0] ins,
                                   input bit zf, input int c);
        exp_t e;
        int   opc;
        e = '{default: 0};
        e.cyc = c;
        e.zf  = zf;
        opc = int'(ins[15:12]);
        if (opc >= 8) begin
            e.alu = 1'b1;
            e.op = ins[14:12];
            e.ra = ins[7:4];
            e.rb = ins[3:0];
            e.wa = ins[11:8];
            e.we3 = 1'b1;
            e.pc_inc = 1'b1;
        end else if (opc == 0) begin
            e.we3 = 1'b1;
            e.s_inm = 1'b1;
            e.inm = {8'h00, ins[7:0]};
            e.wa = ins[11:8];
            e.pc_inc = 1'b1;
        end else if (opc >= 1 && opc <= 3) begin
            bit take;
            take = (opc == 1) || (opc == 2 && zf) || (opc == 3 && !zf);
            e.pc_load = take;
            e.pc_inc = !take;
            e.jaddr = ins[9:0];
        end else if (opc == 4) begin
            e.pc_inc = 1'b1;
        end else begin
            e.pc_inc = 1'b1;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Monitor: decode-cycle fields, then the EXEC cycle per instruction.
    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            chk("pc_excl", {31'd0, pc_inc & pc_load}, 0);
            if (q.size() > 0 && q[0].alu && cyc == q[0].cyc - 1) begin
                chk("dec_op", {29'd0, op_alu}, {29'd0, q[0].op});
                chk("dec_ra", {28'd0, ra_addr}, {28'd0, q[0].ra});
                chk("dec_rb", {28'd0, rb_addr}, {28'd0, q[0].rb});
                chk("dec_quiet", {30'd0, we3, pc_inc}, 0);
            end
            if (pc_inc | pc_load) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_exec: got pc_inc=%0b pc_load=%0b required none",
                             pc_inc, pc_load);
                end else begin
                    e = q.pop_front();
                    chk("exec_cycle", cyc, e.cyc);
                    chk("we3", {31'd0, we3}, {31'd0, e.we3});
                    chk("s_inm", {31'd0, s_inm}, {31'd0, e.s_inm});
                    chk("pc_inc", {31'd0, pc_inc}, {31'd0, e.pc_inc});
                    chk("pc_load", {31'd0, pc_load}, {31'd0, e.pc_load});
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("zflag_prior", {31'd0, zflag}, {31'd0, e.zf});
                    if (e.we3)
                        chk("wa_addr", {28'd0, wa_addr}, {28'd0, e.wa});
                    if (e.s_inm)
                        chk("inm", {16'd0, inm}, {16'd0, e.inm});
                    if (e.we3 && !e.alu)
                        chk("li_op", {29'd0, op_alu}, 0);
                    if (e.alu) begin
                        chk("ex_op", {29'd0, op_alu}, {29'd0, e.op});
                        chk("ex_ra", {28'd0, ra_addr}, {28'd0, e.ra});
                        chk("ex_rb", {28'd0, rb_addr}, {28'd0, e.rb});
                    end
                    if (e.pc_load)
                        chk("jaddr", {22'd0, jaddr}, {22'd0, e.jaddr});
                end
            end else if (q.size() > 0 && cyc >= q[0].cyc) begin
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_exec: got no pc pulse at cycle %0d required one",
                         e.cyc);
            end
        end
    end

    task automatic chk_zero(input string n);
        chk({n, "_outs"},
            {imem_req, op_alu, ra_addr, rb_addr, wa_addr, we3, s_inm,
             pc_inc, pc_load, illegal, jaddr}, 0);
        chk({n, "_inm"}, {16'd0, inm}, 0);
        chk({n, "_zflag"}, {31'd0, zflag}, 0);
        chk({n, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic issue(input logic [15:0] ins, input logic z);
        int n = 0;
        @(negedge clk);
        while (!imem_req && n < 20) begin
            run = 1'b1;
            n++;
            @(negedge clk);
        end
        if (!imem_req) begin
            chk("fetch_timeout", {31'd0, imem_req}, 1);
            return;
        end
        if (jitter) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("fetch_hold", {31'd0, imem_req}, 1);
            end
        end
        instr = ins;
        zero = z;
        imem_ack = 1'b1;
        q.push_back(model(ins, zf_m, cyc + 2));
        if (ins[15]) zf_m = z;
        @(negedge clk);
        imem_ack = 1'b0;
        instr = 16'($urandom);
        if (rand_run) run = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("idle");
        run = 1'b1;
        issue(16'hA123, 1'b1);
        issue(16'h05FF, 1'b0);
        issue(16'h2155, 1'b0);
        issue(16'h3155, 1'b0);
        issue(16'h2155, 1'b1);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_req", {31'd0, imem_req}, 1);
            chk("stall_busy", {31'd0, busy}, 1);
        end
        issue(16'h7000, 1'b0);
        issue(16'h4000, 1'b0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("run_low_busy", {31'd0, busy}, 0);
        chk("run_low_req", {31'd0, imem_req}, 0);
        run = 1'b1;
        issue(16'h9ABC, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_exec");
        q.delete();
        zf_m = 1'b0;
        #1 reset = 1'b0;
        jitter = 1'b1;
        rand_run = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(16'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (4) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
